// File: rtl/mem_responder_legv8_pkg.sv
// Shared definitions for the LEGv8 memory responder: access-size codes,
// responder state encoding and the byte count of each access size.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'b00,
    SZ_HALF  = 2'b01,
    SZ_WORD  = 2'b10,
    SZ_DWORD = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [3:0] SIZE_BYTES [4] = '{4'd1, 4'd2, 4'd4, 4'd8};

  function automatic logic [3:0] bytes_of(input logic [1:0] sz);
    return SIZE_BYTES[sz];
  endfunction

endpackage

// File: rtl/mem_responder_legv8_if.sv
// LEGv8 memory bus. The shared data bus is resolved here from the two
// possible drivers: the datapath (store data) and the responder (load data).
// With MEM_ERROR_EN defined the bus also carries the err completion flag.
interface mem_responder_legv8_if;
  logic [31:0] address;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  size;
  logic        ready;
`ifdef MEM_ERROR_EN
  logic        err;
`endif
  logic [63:0] req_data;
  logic        req_en;
  logic [63:0] resp_data;
  logic        resp_en;
  wire  [63:0] data;

  assign data = req_en  ? req_data  : 64'bz;
  assign data = resp_en ? resp_data : 64'bz;

`ifdef MEM_ERROR_EN
  modport master (output address, mem_read, mem_write, size, req_data, req_en,
                  input ready, err, resp_en, data);
  modport slave  (input address, mem_read, mem_write, size, data,
                  output ready, err, resp_data, resp_en);
`else
  modport master (output address, mem_read, mem_write, size, req_data, req_en,
                  input ready, resp_en, data);
  modport slave  (input address, mem_read, mem_write, size, data,
                  output ready, resp_data, resp_en);
`endif
endinterface

// File: rtl/mem_responder_legv8_lane_align.sv
// Byte-lane steering for little-endian doubleword storage: byte enables,
// store data shifted into its lanes, and load data extracted and zero-extended.
module mem_lane_align
  import mem_bus_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [2:0]  offset,
  input  logic [63:0] wr_data,
  input  logic [63:0] rd_word,
  output logic [7:0]  byte_en,
  output logic [63:0] wr_lanes,
  output logic [63:0] rd_value
);
  logic [7:0]  size_mask;
  logic [63:0] keep;
  logic [63:0] shifted;

  // Width mask positioned at the offset; loads right-justified then masked
  always_comb begin
    size_mask = 8'h00;
    keep      = '0;
    unique case (size)
      SZ_BYTE:  size_mask = 8'h01;
      SZ_HALF:  size_mask = 8'h03;
      SZ_WORD:  size_mask = 8'h0F;
      default:  size_mask = 8'hFF;
    endcase
    byte_en  = size_mask << offset;
    wr_lanes = wr_data << {offset, 3'b000};
    shifted  = rd_word >> {offset, 3'b000};
    for (int i = 0; i < 8; i++) keep[i*8 +: 8] = {8{size_mask[i]}};
    rd_value = shifted & keep;
  end
endmodule

// File: rtl/mem_responder_legv8.sv
// Memory-side responder for the LEGv8 bus: doubleword RAM with byte/half/
// word/dword access, programmable wait states and a one-cycle ready pulse.
// Optional macro MEM_ERROR_EN adds the err flag with misalignment, range and
// read+write-conflict checks; without it addresses are aligned down, the
// word index wraps and read+write acts as a write.
module mem_responder_legv8
  import mem_bus_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          READ_WAIT  = 1,
  parameter int          WRITE_WAIT = 1
) (
  input logic                  clock,
  input logic                  reset_n,
  mem_responder_legv8_if.slave bus
);
  localparam int WORDS = 1 << DEPTH_LOG2;
  localparam int CNT_W = 16;

  state_t                 state, state_next;
  logic [CNT_W-1:0]       cnt, cnt_next;
  logic                   accept, commit;
  logic                   lat_read, lat_write, lat_err;
  logic [1:0]             lat_size;
  logic [2:0]             lat_offset;
  logic [DEPTH_LOG2-1:0]  lat_index;
  logic [63:0]            lat_wdata;
  logic [63:0]            rd_result;
  logic [63:0]            ram [WORDS];

  logic [31:0]            rel;
  logic [2:0]             lane_mask;
  logic [2:0]             req_offset;
  logic                   req_err;
  logic [DEPTH_LOG2-1:0]  req_index;

  logic [7:0]             byte_en;
  logic [63:0]            wr_lanes;
  logic [63:0]            rd_value;

  assign rel       = bus.address - BASE_ADDR;
  assign req_index = rel[DEPTH_LOG2+2:3];
  assign lane_mask = 3'(bytes_of(bus.size) - 4'd1);

`ifdef MEM_ERROR_EN
  logic range_err, align_err, unused_rel;
  assign range_err  = {32'd0, rel} >= (64'd1 << (DEPTH_LOG2 + 3));
  assign align_err  = (bus.address[2:0] & lane_mask) != 3'd0;
  assign req_err    = range_err | align_err | (bus.mem_read & bus.mem_write);
  assign req_offset = bus.address[2:0];
  assign unused_rel = ^rel[2:0];
`else
  logic unused_rel;
  assign req_err    = 1'b0;
  assign req_offset = bus.address[2:0] & ~lane_mask;
  assign unused_rel = ^{rel[31:DEPTH_LOG2+3], rel[2:0]};
`endif

  mem_lane_align u_align (
    .size     (lat_size),
    .offset   (lat_offset),
    .wr_data  (lat_wdata),
    .rd_word  (ram[lat_index]),
    .byte_en  (byte_en),
    .wr_lanes (wr_lanes),
    .rd_value (rd_value)
  );

  // Next-state and wait-counter logic
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    commit     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.mem_read | bus.mem_write) begin
          accept     = 1'b1;
          state_next = WAIT;
          cnt_next   = bus.mem_write ? CNT_W'(WRITE_WAIT - 1) : CNT_W'(READ_WAIT - 1);
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_next = DONE;
          commit     = 1'b1;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Control state: FSM, counter and request classification
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_read  <= 1'b0;
      lat_write <= 1'b0;
      lat_err   <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) begin
        lat_read  <= bus.mem_read & ~bus.mem_write;
        lat_write <= bus.mem_write;
        lat_err   <= req_err;
      end
    end
  end

  // Request capture and registered load result
  always_ff @(posedge clock) begin
    if (accept) begin
      lat_size   <= bus.size;
      lat_offset <= req_offset;
      lat_index  <= req_index;
      lat_wdata  <= bus.data;
    end
    if (commit && lat_read) rd_result <= lat_err ? 64'd0 : rd_value;
  end

  // Store commit into the addressed byte lanes only
  always_ff @(posedge clock) begin
    if (commit && lat_write && !lat_err) begin
      for (int i = 0; i < 8; i++)
        if (byte_en[i]) ram[lat_index][i*8 +: 8] <= wr_lanes[i*8 +: 8];
    end
  end

  assign bus.ready     = (state == DONE);
  assign bus.resp_en   = (state == DONE) & lat_read;
  assign bus.resp_data = rd_result;
`ifdef MEM_ERROR_EN
  assign bus.err       = (state == DONE) & lat_err;
`endif

endmodule

// File: tb/tb_mem_responder_legv8.sv
// Bench for mem_responder_legv8: directed steps plus random traffic checked
// against a byte-array model of the memory. Covers MEM_ERROR_EN when defined.
module tb_mem_responder_legv8;
  import mem_bus_pkg::*;

  localparam int MEM_BYTES = 2048;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   compared   = 0;
  int   mismatched = 0;
  logic [7:0] mbytes [MEM_BYTES];

  mem_responder_legv8_if bus0 ();
  mem_responder_legv8_if bus1 ();

  mem_responder_legv8 u0 (.clock(clock), .reset_n(reset_n), .bus(bus0));
  mem_responder_legv8 #(.READ_WAIT(4), .WRITE_WAIT(2)) u1 (.clock(clock), .reset_n(reset_n), .bus(bus1));

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input int w, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [1:0] sz, input logic [63:0] d);
    if (w == 0) begin
      bus0.mem_read = rd; bus0.mem_write = wr; bus0.address = a;
      bus0.size = sz; bus0.req_data = d; bus0.req_en = wr;
    end else begin
      bus1.mem_read = rd; bus1.mem_write = wr; bus1.address = a;
      bus1.size = sz; bus1.req_data = d; bus1.req_en = wr;
    end
  endtask

  function automatic logic get_ready(input int w);
    return (w == 0) ? bus0.ready : bus1.ready;
  endfunction

  function automatic logic get_en(input int w);
    return (w == 0) ? bus0.resp_en : bus1.resp_en;
  endfunction

  function automatic logic [63:0] get_data(input int w);
    return (w == 0) ? bus0.data : bus1.data;
  endfunction

  function automatic logic get_err(input int w);
`ifdef MEM_ERROR_EN
    return (w == 0) ? bus0.err : bus1.err;
`else
    return (w == 0) ? 1'b0 : 1'b0;
`endif
  endfunction

  // Reference memory behaviour for u0 (BASE_ADDR 0, 2 KiB)
  function automatic void model(input bit rd, input bit wr, input logic [31:0] a,
                                input logic [1:0] sz, input logic [63:0] d,
                                output logic [63:0] exp_rd, output bit exp_err);
    int unsigned nb;
    int unsigned b;
    nb = 1 << sz;
    exp_rd = 64'd0;
    exp_err = 1'b0;
`ifdef MEM_ERROR_EN
    if ((rd && wr) || a >= MEM_BYTES || (a % nb) != 0) begin
      exp_err = 1'b1;
      return;
    end
    b = a;
`else
    b = (a & ~(nb - 1)) % MEM_BYTES;
`endif
    for (int i = 0; i < int'(nb); i++) begin
      if (wr) mbytes[b + i] = d[8*i +: 8];
      else    exp_rd[8*i +: 8] = mbytes[b + i];
    end
  endfunction

  // One transaction: returns the read data and err seen with ready
  task automatic xact(input int w, input bit rd, input bit wr, input logic [31:0] a,
                      input logic [1:0] sz, input logic [63:0] d, input int waitc,
                      output logic [63:0] rdata, output bit errv);
    int k;
    bit seen;
    k = 0;
    seen = 1'b0;
    rdata = 64'd0;
    errv = 1'b0;
    @(posedge clock); #1;
    drive(w, rd, wr, a, sz, d);
    while (!seen && k < 50) begin
      @(negedge clock);
      k++;
      if (get_ready(w)) begin
        seen  = 1'b1;
        rdata = get_data(w);
        errv  = get_err(w);
        check("drive_at_ready", 64'(get_en(w)), 64'(rd && !wr));
      end else begin
        check("hiz", 64'(get_en(w)), 64'd0);
      end
    end
    check("latency", 64'(k), 64'(waitc + 2));
    @(posedge clock); #1;
    drive(w, 1'b0, 1'b0, 32'd0, 2'd0, 64'd0);
    @(negedge clock);
    check("ready_one_cycle", 64'(get_ready(w)), 64'd0);
    check("hiz_after", 64'(get_en(w)), 64'd0);
  endtask

  // u0 transaction compared against the model
  task automatic run(input bit rd, input bit wr, input logic [31:0] a, input logic [1:0] sz,
                     input logic [63:0] d, output logic [63:0] rdata);
    logic [63:0] exp_rd;
    bit exp_err, errv;
    model(rd, wr, a, sz, d, exp_rd, exp_err);
    xact(0, rd, wr, a, sz, d, 1, rdata, errv);
    if (rd && !wr) check("rd_data", rdata, exp_rd);
`ifdef MEM_ERROR_EN
    check("err", 64'(errv), 64'(exp_err));
`endif
  endtask

  initial begin
    logic [63:0] rdata, rdata2, exp_a, exp_b, dtmp;
    bit errv, eb;
    int k;

    drive(0, 0, 0, 32'd0, 2'd0, 64'd0);
    drive(1, 0, 0, 32'd0, 2'd0, 64'd0);
    #1;
    check("rst_ready0", 64'(bus0.ready), 64'd0);
    check("rst_ready1", 64'(bus1.ready), 64'd0);
    check("rst_hiz0", 64'(bus0.resp_en), 64'd0);
    check("rst_err0", 64'(get_err(0)), 64'd0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;

    // Clear the RAM through the bus
    for (int i = 0; i < 256; i++) run(0, 1, 32'(i * 8), SZ_DWORD, 64'd0, rdata);

    // Reset while a write sits in WAIT: write must not land
    @(posedge clock); #1;
    drive(0, 0, 1, 32'd0, SZ_DWORD, 64'h1234);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("rst_mid_ready", 64'(bus0.ready), 64'd0);
    check("rst_mid_hiz", 64'(bus0.resp_en), 64'd0);
    drive(0, 0, 0, 32'd0, 2'd0, 64'd0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    run(1, 0, 32'd0, SZ_DWORD, 64'd0, rdata);
    check("rst_no_commit", 64'(rdata == 64'h1234), 64'd0);

    // Dword round trip and sub-word accesses
    run(0, 1, 32'd24, SZ_DWORD, 64'hFFFF_FFFF_FFFF_FFE8, rdata);
    run(1, 0, 32'd24, SZ_DWORD, 64'd0, rdata);
    check("dword_rt", rdata, 64'hFFFF_FFFF_FFFF_FFE8);
    run(1, 0, 32'd25, SZ_BYTE, 64'd0, rdata);
    check("byte_rd25", rdata, 64'h0000_0000_0000_00FF);
    run(0, 1, 32'd30, SZ_HALF, 64'h0000_0000_0000_ABCD, rdata);
    run(1, 0, 32'd24, SZ_DWORD, 64'd0, rdata);
    check("half_merge", rdata, 64'hABCD_FFFF_FFFF_FFE8);

    // Back-to-back reads with the request held
    model(1, 0, 32'd24, SZ_DWORD, 64'd0, exp_a, eb);
    model(1, 0, 32'd32, SZ_DWORD, 64'd0, exp_b, eb);
    @(posedge clock); #1;
    drive(0, 1, 0, 32'd24, SZ_DWORD, 64'd0);
    k = 0;
    while (!bus0.ready && k < 20) begin @(negedge clock); k++; end
    check("b2b_lat1", 64'(k), 64'd3);
    rdata = bus0.data;
    @(posedge clock); #1;
    bus0.address = 32'd32;
    k = 0;
    do begin @(negedge clock); k++; check("b2b_hiz", 64'(bus0.resp_en), 64'(bus0.ready)); end
    while (!bus0.ready && k < 20);
    check("b2b_gap", 64'(k), 64'd3);
    rdata2 = bus0.data;
    @(posedge clock); #1;
    drive(0, 0, 0, 32'd0, 2'd0, 64'd0);
    check("b2b_data1", rdata, exp_a);
    check("b2b_data2", rdata2, exp_b);

    // Wait states on u1 (WRITE_WAIT=2, READ_WAIT=4)
    dtmp = {$urandom, $urandom};
    xact(1, 0, 1, 32'd8, SZ_DWORD, dtmp, 2, rdata, errv);
    xact(1, 1, 0, 32'd8, SZ_DWORD, 64'd0, 4, rdata, errv);
    check("wait4_data", rdata, dtmp);

`ifdef MEM_ERROR_EN
    run(1, 0, 32'd25, SZ_HALF, 64'd0, rdata);
    check("misalign_data", rdata, 64'd0);
    xact(0, 1, 0, 32'd2048, SZ_DWORD, 64'd0, 1, rdata, errv);
    check("range_err", 64'(errv), 64'd1);
    xact(0, 1, 1, 32'd24, SZ_DWORD, 64'h5555_5555_5555_5555, 1, rdata, errv);
    check("rdwr_err", 64'(errv), 64'd1);
    run(1, 0, 32'd24, SZ_DWORD, 64'd0, rdata);
    check("rdwr_no_effect", rdata, 64'hABCD_FFFF_FFFF_FFE8);
`else
    run(1, 0, 32'd25, SZ_HALF, 64'd0, rdata);
    check("align_down", rdata, 64'h0000_0000_0000_FFE8);
    run(1, 1, 32'd40, SZ_DWORD, 64'h0123_4567_89AB_CDEF, rdata);
    run(1, 0, 32'd40, SZ_DWORD, 64'd0, rdata);
    check("rdwr_as_write", rdata, 64'h0123_4567_89AB_CDEF);
    run(1, 0, 32'd2048 + 32'd24, SZ_DWORD, 64'd0, rdata);
    check("index_wrap", rdata, 64'hABCD_FFFF_FFFF_FFE8);
`endif

    // Random traffic against the model
    for (int n = 0; n < 200; n++) begin
      int unsigned r;
      logic [31:0] a;
      r = $urandom_range(0, 7);
      a = ($urandom_range(0, 9) == 0) ? 32'($urandom) : 32'($urandom_range(0, MEM_BYTES - 1));
      run(r == 0 || r > 3, r <= 3, a, 2'($urandom_range(0, 3)), {$urandom, $urandom}, rdata);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
